// File: rtl/ieeedrv_trkparse.sv
// ieeedrv_trkparse: finds a track/sector header in the read stream, checks it and writes the data block to a sector buffer.
module ieeedrv_trkparse #(
  parameter int MAX_HDR  = 48,
  parameter int DATA_WIN = 40,
  parameter int MIN_SYNC = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req,
  input  logic        abort,
  input  logic [7:0]  req_track,
  input  logic [4:0]  req_sector,
  input  logic [15:0] req_id,
  input  logic        chk_id,
  input  logic        byte_stb,
  input  logic        sync_n,
  input  logic [7:0]  byte_in,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [15:0] hdr_id,
  output logic [7:0]  buf_addr,
  output logic [7:0]  buf_data,
  output logic        buf_we
);
  typedef enum logic [2:0] {IDLE, HUNT, HEADER, DWAIT, DATA, DCHK} state_t;
  localparam logic [2:0] ST_OK = 3'd0, ST_NOHDR = 3'd1, ST_HCHK = 3'd2, ST_IDMIS = 3'd3,
                         ST_NOSYNC = 3'd4, ST_DCHK = 3'd5, ST_ABORT = 3'd6;
  localparam logic [2:0] MS  = 3'(MIN_SYNC);
  localparam logic [7:0] HM  = 8'(MAX_HDR);
  localparam logic [7:0] WIN = 8'(DATA_WIN);
  state_t state;
  logic [7:0]  r_track;
  logic [4:0]  r_sector;
  logic [15:0] r_id;
  logic        r_chk_id;
  logic [2:0]  sync_cnt, hb;
  logic [7:0]  hdr_cnt, win_cnt, addr, acc, h_chk, h_sec, h_trk, h_idhi;
  logic [2:0]  sync_nx;
  logic [7:0]  hdr_cnt_nx, win_nx;
  logic        code_ok, hdr_match, hdr_chk_ok;
  assign sync_nx    = sync_cnt == 3'd7 ? 3'd7 : sync_cnt + 3'd1;
  assign hdr_cnt_nx = hdr_cnt + 8'd1;
  assign win_nx     = win_cnt + 8'd1;
  assign code_ok    = sync_n && sync_cnt >= MS;
  assign hdr_match  = h_trk == r_track && h_sec == {3'b000, r_sector};
  assign hdr_chk_ok = h_chk == (h_sec ^ h_trk ^ h_idhi ^ byte_in);
  task automatic fin(input logic [2:0] s);
    busy   <= 1'b0;
    done   <= 1'b1;
    status <= s;
    state  <= IDLE;
  endtask
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      status   <= 3'd0;
      hdr_id   <= 16'd0;
      buf_addr <= 8'd0;
      buf_data <= 8'd0;
      buf_we   <= 1'b0;
      r_track  <= 8'd0;
      r_sector <= 5'd0;
      r_id     <= 16'd0;
      r_chk_id <= 1'b0;
      sync_cnt <= 3'd0;
      hb       <= 3'd0;
      hdr_cnt  <= 8'd0;
      win_cnt  <= 8'd0;
      addr     <= 8'd0;
      acc      <= 8'd0;
      h_chk    <= 8'd0;
      h_sec    <= 8'd0;
      h_trk    <= 8'd0;
      h_idhi   <= 8'd0;
    end else begin
      done   <= 1'b0;
      buf_we <= 1'b0;
      if (busy && abort) fin(ST_ABORT);
      else if (state == IDLE) begin
        // done still high means the operation finished this cycle; its req is dropped
        if (req && !done) begin
          r_track  <= req_track;
          r_sector <= req_sector;
          r_id     <= req_id;
          r_chk_id <= chk_id;
          busy     <= 1'b1;
          status   <= ST_OK;
          hdr_cnt  <= 8'd0;
          sync_cnt <= 3'd0;
          state    <= HUNT;
        end
      end else if (byte_stb) begin
        case (state)
          HUNT: begin
            sync_cnt <= sync_n ? 3'd0 : sync_nx;
            if (code_ok && byte_in == 8'h08) begin
              state <= HEADER;
              hb    <= 3'd0;
            end
          end
          HEADER: begin
            if (!sync_n) begin
              state    <= HUNT;
              sync_cnt <= 3'd1;
            end else if (hb != 3'd4) begin
              hb <= hb + 3'd1;
              if (hb == 3'd0) h_chk <= byte_in;
              if (hb == 3'd1) h_sec <= byte_in;
              if (hb == 3'd2) h_trk <= byte_in;
              if (hb == 3'd3) h_idhi <= byte_in;
            end else begin
              hdr_cnt <= hdr_cnt_nx;
              if (hdr_match) begin
                hdr_id <= {h_idhi, byte_in};
                if (!hdr_chk_ok) fin(ST_HCHK);
                else if (r_chk_id && {h_idhi, byte_in} != r_id) fin(ST_IDMIS);
                else begin
                  state   <= DWAIT;
                  win_cnt <= 8'd0;
                end
              end else if (hdr_cnt_nx == HM) fin(ST_NOHDR);
              else state <= HUNT;
            end
          end
          DWAIT: begin
            win_cnt  <= win_nx;
            sync_cnt <= sync_n ? 3'd0 : sync_nx;
            if (code_ok && byte_in == 8'h07) begin
              state <= DATA;
              addr  <= 8'd0;
              acc   <= 8'd0;
            end else if (code_ok || win_nx == WIN) fin(ST_NOSYNC);
          end
          DATA: begin
            if (!sync_n) fin(ST_DCHK);
            else begin
              buf_we   <= 1'b1;
              buf_addr <= addr;
              buf_data <= byte_in;
              acc      <= acc ^ byte_in;
              addr     <= addr + 8'd1;
              if (addr == 8'hFF) state <= DCHK;
            end
          end
          DCHK: fin(byte_in == acc ? ST_OK : ST_DCHK);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ieeedrv_trkparse.sv
// tb_ieeedrv_trkparse: directed stream scenarios for the track parser.
module tb_ieeedrv_trkparse;
  logic        clk_sys = 0, reset = 1, req = 0, abort = 0, chk_id = 0;
  logic        byte_stb = 0, sync_n = 1;
  logic [7:0]  req_track = 0, byte_in = 0;
  logic [4:0]  req_sector = 0;
  logic [15:0] req_id = 0;
  logic        busy, done, buf_we;
  logic [2:0]  status;
  logic [15:0] hdr_id;
  logic [7:0]  buf_addr, buf_data;
  int total = 0, bad = 0, we_cnt = 0, done_cnt = 0, addr_err = 0;

  ieeedrv_trkparse dut (
    .clk_sys(clk_sys), .reset(reset), .req(req), .abort(abort),
    .req_track(req_track), .req_sector(req_sector), .req_id(req_id), .chk_id(chk_id),
    .byte_stb(byte_stb), .sync_n(sync_n), .byte_in(byte_in),
    .busy(busy), .done(done), .status(status), .hdr_id(hdr_id),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (buf_we === 1'b1) begin
      we_cnt++;
      if (buf_addr !== buf_data) addr_err++;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic sb(input logic s, input logic [7:0] b);
    byte_stb = 1; sync_n = !s; byte_in = b;
    tick;
    byte_stb = 0; sync_n = 1;
    tick;
  endtask

  task automatic syncs(input int n);
    for (int i = 0; i < n; i++) sb(1, 8'hFF);
  endtask

  function automatic logic [7:0] hx(input logic [7:0] sec, trk, hi, lo);
    return sec ^ trk ^ hi ^ lo;
  endfunction

  task automatic hdr(input logic [7:0] ck, sec, trk, hi, lo);
    sb(0, 8'h42);
    syncs(3);
    sb(0, 8'h08);
    sb(0, ck); sb(0, sec); sb(0, trk); sb(0, hi); sb(0, lo);
  endtask

  task automatic gap;
    for (int i = 0; i < 5; i++) sb(0, 8'h55);
  endtask

  task automatic dblk(input int bad_idx, input int n, input logic [7:0] ck);
    syncs(3);
    sb(0, 8'h07);
    for (int i = 0; i < n; i++) sb(0, i == bad_idx ? 8'hEE : 8'(i));
    if (n == 256) sb(0, ck);
  endtask

  task automatic start(input logic [7:0] trk, input logic [4:0] sec, input logic [15:0] id, input logic cid);
    req_track = trk; req_sector = sec; req_id = id; chk_id = cid;
    req = 1;
    tick;
    req = 0;
    we_cnt = 0; done_cnt = 0; addr_err = 0;
  endtask

  task automatic test_reset;
    reset = 1; tick; tick; reset = 0; tick;
    total++;
    if ({busy, done, status, hdr_id, buf_addr, buf_data, buf_we} !== 45'd0) begin
      bad++; $display("FAIL reset_outputs got busy=%b done=%b status=%0d hdr_id=%h addr=%h data=%h we=%b want all 0",
                      busy, done, status, hdr_id, buf_addr, buf_data, buf_we);
    end
  endtask

  task automatic test_ok;
    start(8'd10, 5'd5, 16'h4142, 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ok_busy got %b want 1", busy); end
    hdr(8'h0C, 8'd5, 8'd10, 8'h41, 8'h42);
    gap;
    dblk(-1, 256, 8'h00);
    tick;
    total++; if (status !== 3'd0) begin bad++; $display("FAIL ok_status got %0d want 0", status); end
    total++; if (we_cnt !== 256) begin bad++; $display("FAIL ok_writes got %0d want 256", we_cnt); end
    total++; if (addr_err !== 0) begin bad++; $display("FAIL ok_addr_eq_data got %0d errors want 0", addr_err); end
    total++; if (done_cnt !== 1 || busy !== 1'b0) begin bad++; $display("FAIL ok_done got done=%0d busy=%b want 1,0", done_cnt, busy); end
    total++; if (hdr_id !== 16'h4142) begin bad++; $display("FAIL ok_hdr_id got %h want 4142", hdr_id); end
  endtask

  task automatic test_hdr_chk;
    start(8'd10, 5'd5, 16'h4142, 0);
    hdr(8'h0D, 8'd5, 8'd10, 8'h41, 8'h42);
    gap;
    dblk(-1, 256, 8'h00);
    total++; if (status !== 3'd2) begin bad++; $display("FAIL hdr_chk_status got %0d want 2", status); end
    total++; if (we_cnt !== 0 || done_cnt !== 1) begin bad++; $display("FAIL hdr_chk_writes got we=%0d done=%0d want 0,1", we_cnt, done_cnt); end
  endtask

  task automatic test_id_mismatch;
    start(8'd10, 5'd5, 16'h4142, 1);
    hdr(8'h0D, 8'd5, 8'd10, 8'h41, 8'h43);
    total++; if (status !== 3'd3) begin bad++; $display("FAIL id_status got %0d want 3", status); end
    total++; if (hdr_id !== 16'h4143) begin bad++; $display("FAIL id_hdr_id got %h want 4143", hdr_id); end
  endtask

  task automatic test_not_found;
    start(8'd10, 5'd25, 16'h4142, 0);
    for (int i = 0; i < 47; i++)
      hdr(hx(8'(i % 21), 8'd10, 8'h41, 8'h42), 8'(i % 21), 8'd10, 8'h41, 8'h42);
    total++; if (done_cnt !== 0 || busy !== 1'b1) begin bad++; $display("FAIL nf_47 got done=%0d busy=%b want 0,1", done_cnt, busy); end
    hdr(hx(8'd5, 8'd10, 8'h41, 8'h42), 8'd5, 8'd10, 8'h41, 8'h42);
    total++; if (status !== 3'd1 || done_cnt !== 1) begin bad++; $display("FAIL nf_48 got status=%0d done=%0d want 1,1", status, done_cnt); end
  endtask

  task automatic test_no_sync;
    start(8'd10, 5'd5, 16'h4142, 0);
    hdr(8'h0C, 8'd5, 8'd10, 8'h41, 8'h42);
    for (int i = 0; i < 39; i++) sb(0, 8'h55);
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL win_39 got done=%0d want 0", done_cnt); end
    sb(0, 8'h55);
    total++; if (status !== 3'd4 || done_cnt !== 1) begin bad++; $display("FAIL win_40 got status=%0d done=%0d want 4,1", status, done_cnt); end
    start(8'd10, 5'd5, 16'h4142, 0);
    hdr(8'h0C, 8'd5, 8'd10, 8'h41, 8'h42);
    sb(0, 8'h55); sb(0, 8'h55); sb(0, 8'h55);
    syncs(3);
    sb(0, 8'h08);
    total++; if (status !== 3'd4 || we_cnt !== 0) begin bad++; $display("FAIL win_08 got status=%0d we=%0d want 4,0", status, we_cnt); end
  endtask

  task automatic test_data_chk;
    start(8'd10, 5'd5, 16'h4142, 0);
    hdr(8'h0C, 8'd5, 8'd10, 8'h41, 8'h42);
    gap;
    dblk(17, 256, 8'h00);
    total++; if (status !== 3'd5 || we_cnt !== 256) begin bad++; $display("FAIL dchk got status=%0d we=%0d want 5,256", status, we_cnt); end
    start(8'd10, 5'd5, 16'h4142, 0);
    hdr(8'h0C, 8'd5, 8'd10, 8'h41, 8'h42);
    gap;
    dblk(-1, 10, 8'h00);
    sb(1, 8'hFF);
    total++; if (status !== 3'd5 || we_cnt !== 10) begin bad++; $display("FAIL dsync got status=%0d we=%0d want 5,10", status, we_cnt); end
  endtask

  task automatic test_abort;
    start(8'd10, 5'd5, 16'h4142, 0);
    hdr(8'h0C, 8'd5, 8'd10, 8'h41, 8'h42);
    gap;
    dblk(-1, 100, 8'h00);
    abort = 1; byte_stb = 1; byte_in = 8'd100;
    tick;
    abort = 0; byte_stb = 0;
    total++; if (busy !== 1'b0 || done !== 1'b1 || status !== 3'd6) begin bad++; $display("FAIL abort_now got busy=%b done=%b status=%0d want 0,1,6", busy, done, status); end
    tick;
    total++; if (we_cnt !== 100 || done_cnt !== 1) begin bad++; $display("FAIL abort_writes got we=%0d done=%0d want 100,1", we_cnt, done_cnt); end
  endtask

  task automatic test_reset_mid;
    start(8'd10, 5'd5, 16'h4142, 0);
    hdr(8'h0C, 8'd5, 8'd10, 8'h41, 8'h42);
    gap;
    dblk(-1, 100, 8'h00);
    reset = 1; tick; reset = 0;
    total++; if ({busy, done, status, hdr_id, buf_addr, buf_data, buf_we} !== 45'd0) begin
      bad++; $display("FAIL rst_mid_outputs got busy=%b done=%b status=%0d hdr_id=%h addr=%h we=%b want all 0",
                      busy, done, status, hdr_id, buf_addr, buf_we);
    end
    for (int i = 0; i < 5; i++) sb(0, 8'h11);
    total++; if (done_cnt !== 0 || we_cnt !== 100) begin bad++; $display("FAIL rst_mid_pulse got done=%0d we=%0d want 0,100", done_cnt, we_cnt); end
  endtask

  task automatic test_back_to_back;
    start(8'd10, 5'd5, 16'h4142, 0);
    sb(0, 8'h42); syncs(3); sb(0, 8'h08);
    sb(0, 8'h0D); sb(0, 8'd5); sb(0, 8'd10); sb(0, 8'h41);
    byte_stb = 1; sync_n = 1; byte_in = 8'h42;
    tick;
    byte_stb = 0;
    total++; if (done !== 1'b1 || status !== 3'd2) begin bad++; $display("FAIL b2b_done got done=%b status=%0d want 1,2", done, status); end
    req = 1; tick; req = 0;
    total++; if (busy !== 1'b0 || status !== 3'd2) begin bad++; $display("FAIL b2b_req_ignored got busy=%b status=%0d want 0,2", busy, status); end
    req = 1; tick; req = 0;
    total++; if (busy !== 1'b1 || status !== 3'd0) begin bad++; $display("FAIL b2b_req_next got busy=%b status=%0d want 1,0", busy, status); end
    abort = 1; tick; abort = 0; tick;
    done_cnt = 0;
    abort = 1; tick; tick; abort = 0; tick;
    total++; if (done_cnt !== 0 || status !== 3'd6 || busy !== 1'b0) begin bad++; $display("FAIL idle_abort got done=%0d status=%0d busy=%b want 0,6,0", done_cnt, status, busy); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ok;
    test_hdr_chk;
    test_id_mismatch;
    test_not_found;
    test_no_sync;
    test_data_chk;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
